// File: rtl/control_modes_if.sv
// Front-panel bundle: debounced buttons in, mode state and request pulses out.
// Pulses carry no ready: each is high for one cycle and must be taken in that cycle.
interface control_modes_if #(
  parameter int NUM_MODES = 2
);
  logic                 b1;
  logic                 b2;
  logic                 b3;
  logic [2:0]           mode;
  logic [NUM_MODES-1:0] mode_active;
  logic                 inc_pulse;
  logic                 dec_pulse;
  logic                 stop_pulse;
  logic                 timeout_pulse;

  modport master (
    output b1, b2, b3,
    input  mode, mode_active, inc_pulse, dec_pulse, stop_pulse, timeout_pulse
  );

  modport slave (
    input  b1, b2, b3,
    output mode, mode_active, inc_pulse, dec_pulse, stop_pulse, timeout_pulse
  );
endinterface

// File: rtl/control_modes.sv
// Front-panel mode controller: per-button short/long/repeat classifier feeding
// an idle/setting-mode FSM with an inactivity timeout. All outputs registered.
module control_modes #(
  parameter int NUM_MODES      = 2,
  parameter int LONG_CYCLES    = 1000,
  parameter int REPEAT_CYCLES  = 250,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic            clock,
  input  logic            reset_n,
  control_modes_if.slave  bus
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES);

  typedef enum logic {ST_IDLE, ST_SET} state_t;

  logic [2:0]    btn;
  logic [2:0]    armed;
  logic [CW-1:0] hold_cnt [3];
  logic [RW-1:0] rep_cnt  [2];
  logic [2:0]    long_ev;
  logic [2:0]    short_ev;
  logic [1:0]    rep_ev;

  assign btn = {bus.b3, bus.b2, bus.b1};

  // Classifier. hold_cnt saturates at LONG_CYCLES, which marks "long already
  // reported" so the release after a long press stays silent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed    <= '0;
      long_ev  <= '0;
      short_ev <= '0;
      rep_ev   <= '0;
      for (int i = 0; i < 3; i++) hold_cnt[i] <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i]  <= '0;
    end else begin
      long_ev  <= '0;
      short_ev <= '0;
      rep_ev   <= '0;
      for (int i = 0; i < 3; i++) begin
        if (!armed[i]) begin
          armed[i] <= ~btn[i];
        end else if (btn[i]) begin
          if (hold_cnt[i] == LONG_LAST) begin
            hold_cnt[i] <= LONG_MAX;
            long_ev[i]  <= 1'b1;
          end else if (hold_cnt[i] != LONG_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
        end else begin
          short_ev[i] <= (hold_cnt[i] != '0) && (hold_cnt[i] != LONG_MAX);
          hold_cnt[i] <= '0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (armed[i] && btn[i] && (hold_cnt[i] == LONG_MAX)) begin
          if (rep_cnt[i] == REP_LAST) begin
            rep_cnt[i] <= '0;
            rep_ev[i]  <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + 1'b1;
          end
        end else begin
          rep_cnt[i] <= '0;
        end
      end
    end
  end

  logic ev1, ev2, ev3, ev_any;
  assign ev1    = long_ev[0] | short_ev[0] | rep_ev[0];
  assign ev2    = long_ev[1] | short_ev[1] | rep_ev[1];
  assign ev3    = long_ev[2] | short_ev[2];
  assign ev_any = ev1 | ev2 | ev3;

  state_t               state, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [NUM_MODES-1:0] active_q, active_d;
  logic [TW-1:0]        tcnt, tcnt_d;
  logic                 inc_q, inc_d, dec_q, dec_d;
  logic                 stop_q, stop_d, to_q, to_d;

  // Only the highest-priority button (b3 > b1 > b2) with any event acts.
  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    stop_d  = 1'b0;
    to_d    = 1'b0;
    if (ev3) begin
      if (long_ev[2]) begin
        stop_d  = 1'b1;
        state_d = ST_IDLE;
        mode_d  = 3'd0;
      end else if (state == ST_SET) begin
        if (mode_q == MODE_LAST) begin
          state_d = ST_IDLE;
          mode_d  = 3'd0;
        end else begin
          mode_d = mode_q + 3'd1;
        end
      end
    end else if (ev1) begin
      if (state == ST_IDLE) begin
        if (long_ev[0]) begin
          state_d = ST_SET;
          mode_d  = 3'd1;
        end
      end else begin
        inc_d = 1'b1;
      end
    end else if (ev2) begin
      if (state == ST_IDLE) begin
        if (long_ev[1]) begin
          state_d = ST_SET;
          mode_d  = (NUM_MODES == 1) ? 3'd1 : 3'd2;
        end
      end else begin
        dec_d = 1'b1;
      end
    end else if ((state == ST_SET) && (tcnt == TO_LAST)) begin
      to_d    = 1'b1;
      state_d = ST_IDLE;
      mode_d  = 3'd0;
    end

    if (ev_any || (mode_d != mode_q) || (state == ST_IDLE)) tcnt_d = '0;
    else                                                    tcnt_d = tcnt + 1'b1;

    for (int i = 0; i < NUM_MODES; i++) active_d[i] = (mode_d == 3'(i + 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mode_q   <= 3'd0;
      active_q <= '0;
      tcnt     <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      stop_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      tcnt     <= tcnt_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      stop_q   <= stop_d;
      to_q     <= to_d;
    end
  end

  assign bus.mode          = mode_q;
  assign bus.mode_active   = active_q;
  assign bus.inc_pulse     = inc_q;
  assign bus.dec_pulse     = dec_q;
  assign bus.stop_pulse    = stop_q;
  assign bus.timeout_pulse = to_q;

endmodule

// File: tb/tb_control_modes.sv
// Bench for control_modes: every observed output change or pulse is matched,
// cycle-exact, against an expected-event queue filled by the stimulus.
module tb_control_modes;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_INC  = 4'b0001;
  localparam logic [3:0] P_DEC  = 4'b0010;
  localparam logic [3:0] P_STOP = 4'b0100;
  localparam logic [3:0] P_TO   = 4'b1000;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  control_modes_if #(.NUM_MODES(3)) bus ();

  control_modes #(
    .NUM_MODES(3), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT_CYCLES(32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  prev_mode = 3'd0;
  logic [2:0]  prev_active = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // word: [31:16] cycle, [9:6] {timeout,stop,dec,inc}, [5:3] mode, [2:0] one-hot
  function automatic logic [31:0] mk_word(input int c, input logic [3:0] p, input logic [2:0] m);
    logic [2:0] a;
    a = 3'b000;
    if (m != 3'd0) a[int'(m) - 1] = 1'b1;
    return {c[15:0], 6'b0, p, m, a};
  endfunction

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [2:0] m);
    exp_q.push_back(mk_word(c, p, m));
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_mode   <= 3'd0;
      prev_active <= 3'd0;
    end else if (bus.inc_pulse || bus.dec_pulse || bus.stop_pulse || bus.timeout_pulse ||
                 (bus.mode != prev_mode) || (bus.mode_active != prev_active)) begin
      if (exp_q.size() > 0)
        check("event", {cyc[15:0], 6'b0, bus.timeout_pulse, bus.stop_pulse, bus.dec_pulse,
                        bus.inc_pulse, bus.mode, bus.mode_active}, exp_q.pop_front());
      else
        check("spurious_event", {cyc[15:0], 6'b0, bus.timeout_pulse, bus.stop_pulse,
                                 bus.dec_pulse, bus.inc_pulse, bus.mode, bus.mode_active},
              mk_word(cyc, P_NONE, prev_mode));
      prev_mode   <= bus.mode;
      prev_active <= bus.mode_active;
    end
  end

  // drivers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      1:       bus.b1 = v;
      2:       bus.b2 = v;
      default: bus.b3 = v;
    endcase
  endtask

  task automatic press(input int which, input int n);
    set_btn(which, 1'b1);
    tick(n);
    set_btn(which, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mode"},   {29'b0, bus.mode},        32'd0);
    check({tag, "_active"}, {29'b0, bus.mode_active}, 32'd0);
    check({tag, "_inc"},    {31'b0, bus.inc_pulse},     32'd0);
    check({tag, "_dec"},    {31'b0, bus.dec_pulse},     32'd0);
    check({tag, "_stop"},   {31'b0, bus.stop_pulse},    32'd0);
    check({tag, "_to"},     {31'b0, bus.timeout_pulse}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int e;
    reset_n = 1'b1;
    bus.b1  = 1'b0;
    bus.b2  = 1'b0;
    bus.b3  = 1'b0;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check_outputs_zero("reset");
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // long b1 enters SET(1); short b1 increments
    k = cyc; expect_ev(k + 9, P_NONE, 3'd1);
    press(1, 8); tick(3);
    k = cyc; expect_ev(k + 4, P_INC, 3'd1);
    press(1, 2); tick(3);

    // b2 held 20: long then repeats at samples 12, 16, 20
    k = cyc;
    expect_ev(k + 9,  P_DEC, 3'd1);
    expect_ev(k + 13, P_DEC, 3'd1);
    expect_ev(k + 17, P_DEC, 3'd1);
    expect_ev(k + 21, P_DEC, 3'd1);
    press(2, 20); tick(3);

    // short b3 walks through modes and wraps to idle
    for (int m = 2; m <= 4; m++) begin
      k = cyc; expect_ev(k + 4, P_NONE, 3'(m % 4));
      press(3, 2); tick(3);
    end

    // long b2 from idle enters SET(2), then times out after 32 quiet cycles
    k = cyc;
    expect_ev(k + 9,  P_NONE, 3'd2);
    expect_ev(k + 41, P_TO,   3'd0);
    press(2, 8);
    wait_until(k + 45);

    // short b1 lands on the timeout cycle: event wins, counter restarts
    k = cyc; e = k + 9;
    expect_ev(e,      P_NONE, 3'd2);
    expect_ev(e + 32, P_INC,  3'd2);
    expect_ev(e + 64, P_TO,   3'd0);
    press(2, 8);
    wait_until(e + 28);
    press(1, 2);
    wait_until(e + 68);

    // b3 and b1 reach long together in SET(1): stop only
    k = cyc; expect_ev(k + 9, P_NONE, 3'd1);
    press(1, 8); tick(3);
    k = cyc; expect_ev(k + 9, P_STOP, 3'd0);
    bus.b1 = 1'b1; bus.b3 = 1'b1;
    tick(8);
    bus.b1 = 1'b0; bus.b3 = 1'b0;
    tick(3);
    k = cyc; expect_ev(k + 9, P_STOP, 3'd0);
    press(3, 8); tick(3);

    // b1 held through reset release: no events
    bus.b1 = 1'b1;
    tick(1);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    bus.b1 = 1'b0;
    tick(5);
    check("held_through_reset_mode", {29'b0, bus.mode}, 32'd0);

    // reset mid-hold in SET(1): immediate zero outputs, nothing afterwards
    k = cyc; expect_ev(k + 9, P_NONE, 3'd1);
    press(1, 8); tick(3);
    bus.b2 = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    tick(1);
    bus.b2 = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(15);
    check("after_mid_reset_mode", {29'b0, bus.mode}, 32'd0);

    check("leftover_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_modes.md
# control_modes

Parametrised front-panel mode controller for the clock/alarm design. It classifies each of three debounced buttons into short, long and auto-repeat presses internally, and runs a mode state machine with 1..NUM_MODES setting modes plus idle. It emits registered single-cycle increment, decrement, stop and timeout pulses to the timekeeping and alarm blocks. The inactivity timeout returns the block to idle automatically.

## Interface
- NUM_MODES, 2, number of setting modes (1..7); mode 1 = clock set, mode 2 = alarm set, higher = extra settings
- LONG_CYCLES, 1000, consecutive high samples that qualify a long press (>=2)
- REPEAT_CYCLES, 250, period of auto-repeat pulses after a long b1/b2 press (>=1)
- TIMEOUT_CYCLES, 10000, cycles without any press event before a setting mode is abandoned (>=2)
- clock  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- b1  in  1  up/enter button, debounced, synchronous, active-high
- b2  in  1  down button, same conditions as b1
- b3  in  1  mode/stop button, same conditions as b1
- mode  out  3  0 = idle, k = setting mode k
- mode_active  out  NUM_MODES  one-hot of mode; bit k-1 high in mode k; all zero in idle
- inc_pulse  out  1  one-cycle increment request
- dec_pulse  out  1  one-cycle decrement request
- stop_pulse  out  1  one-cycle stop/silence request
- timeout_pulse  out  1  one-cycle flag that the timeout forced idle

## Operation
- Classifier, per button:
  - Saturating hold counter, width clog2(LONG_CYCLES+1).
  - Long event on the LONG_CYCLES-th consecutive high sample.
  - Short event on the first low sample after 1..LONG_CYCLES-1 high samples.
  - Releasing after a long event yields nothing.
  - b1/b2 only: after a long event, repeat event every REPEAT_CYCLES further high samples, until release.
- Arming: after reset, a button is ignored until it has been sampled low once. A button held through reset therefore produces no event.
- States IDLE (mode=0) and SET(k), k=1..NUM_MODES.
- IDLE:
  - long b3 -> stop_pulse.
  - long b1 -> SET(1).
  - long b2 -> SET(2); SET(1) if NUM_MODES=1.
  - Short events are ignored.
- SET(k):
  - long b3 -> stop_pulse, go to IDLE.
  - short b3 -> SET(k+1); from SET(NUM_MODES) go to IDLE (wrap).
  - short, long or repeat on b1 -> inc_pulse.
  - short, long or repeat on b2 -> dec_pulse.
- Same-cycle events, priority b3 > b1 > b2. Only the highest-priority event acts; the others are discarded.
- Timeout counter:
  - Cleared on any event and on every mode change.
  - Counts only in SET(k).
  - On reaching TIMEOUT_CYCLES: timeout_pulse, go to IDLE.
  - If an event occurs in the same cycle as timeout, the event wins and the counter clears.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous assert, synchronous release): mode=0, mode_active=0, all pulses 0, all counters 0, all buttons disarmed.
- Event latency: event detected at edge N -> pulse/mode change visible after edge N+1.
  - Long: LONG_CYCLES+1 edges after the first high sample.
  - Short: 1 edge after the release sample.
- Repeat pulses are spaced exactly REPEAT_CYCLES clocks apart, starting REPEAT_CYCLES after the long pulse.
- Pulses are exactly one cycle. Back-to-back pulses are allowed on consecutive cycles.
- Reset mid-press or mid-mode: state is abandoned immediately and no pulse is emitted.

## Test plan
Parameters: NUM_MODES=3, LONG_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=32.

1. b1 high 8 cycles from IDLE -> mode=1, mode_active=3'b001 one edge after the 8th sample; no pulse on release. Then b1 high 2 cycles -> one inc_pulse after release.
2. In SET(1), hold b2 20 cycles:
   - dec_pulse after sample 8, then after samples 12, 16, 20 (4 pulses total).
   - None on release.
3. In SET(1), short b3 three times -> mode 2, 3, then 0; mode_active 010, 100, 000.
4. In SET(2), no input for 32 cycles -> timeout_pulse for one cycle, mode=0. Repeat with a short b1 at cycle 31 -> no timeout, inc_pulse, counter restarts.
5. In SET(1), b3 and b1 both reach long on the same cycle -> stop_pulse only, mode=0, no inc_pulse. Separately, in IDLE, b3 long -> stop_pulse, mode stays 0.
6. b1 held high through reset_n release for 20 cycles -> no events. reset_n asserted during a 5-cycle hold in SET(1) -> outputs 0 immediately, mode=0, no pulse after release.
